seu_mem_scrubber: RTL

- Background scrubber for SRAM words protected by the 32-bit SEC-DED code: 26 data bits, 5 Hamming bits and 1 overall parity bit.
- Walks the memory one word at a time and decodes each word with hamming32t26d_dec.
- Single error: re-encodes the word with hamming32t26d_enc and writes it back.
- Double error: logs the address and raises an event.
- Sits beside the memory's functional port. It is the lowest-priority requester on a shared req/gnt memory port.

---
 rtl/seu_scrub_pkg.sv | 13 +
 rtl/hamming32t26d_dec.sv | 31 +++
 rtl/hamming32t26d_enc.sv | 29 ++
 rtl/seu_scrub_errlog.sv | 39 +++
 rtl/seu_mem_scrubber.sv | 121 ++++++++++++
 5 files changed

// File: rtl/seu_scrub_pkg.sv
// Shared types and constants for the SEC-DED memory scrubber.
package seu_scrub_pkg;
  localparam int unsigned CW_WIDTH   = 32;
  localparam int unsigned DATA_WIDTH = 26;
  localparam int unsigned SYN_WIDTH  = 5;

  typedef enum logic [2:0] {WAIT, RD, RWAIT, CHK, WR, NEXT} scrub_state_t;

  // Codeword bit 0 is overall parity; Hamming check bits sit at power-of-two positions.
  function automatic logic is_check_pos(input int unsigned pos);
    return (pos & (pos - 1)) == 0;
  endfunction
endpackage

// File: rtl/hamming32t26d_dec.sv
// SEC-DED decoder: syndrome, overall parity and single-error-corrected data.
module hamming32t26d_dec
  import seu_scrub_pkg::*;
(
  input  logic [CW_WIDTH-1:0]   code_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [SYN_WIDTH-1:0]  syndrome_o,
  output logic                  parity_o
);
  always_comb begin
    logic [SYN_WIDTH-1:0] syn;
    logic [CW_WIDTH-1:0]  corr;
    int unsigned          j;
    syn = '0;
    for (int unsigned k = 0; k < SYN_WIDTH; k++)
      for (int unsigned pos = 1; pos < CW_WIDTH; pos++)
        if (pos[k]) syn[k] = syn[k] ^ code_i[pos];
    corr = code_i;
    if ((^code_i) && (syn != '0)) corr[syn] = ~corr[syn];
    data_o = '0;
    j      = 0;
    for (int unsigned pos = 1; pos < CW_WIDTH; pos++) begin
      if (!is_check_pos(pos)) begin
        data_o[j] = corr[pos];
        j++;
      end
    end
    syndrome_o = syn;
    parity_o   = ^code_i;
  end
endmodule

// File: rtl/hamming32t26d_enc.sv
// SEC-DED encoder: 26 data bits -> 32-bit codeword (Hamming positions 1..31, parity at bit 0).
module hamming32t26d_enc
  import seu_scrub_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CW_WIDTH-1:0]   code_o
);
  always_comb begin
    logic [CW_WIDTH-1:0] cw;
    logic                p;
    int unsigned         j;
    cw = '0;
    j  = 0;
    for (int unsigned pos = 1; pos < CW_WIDTH; pos++) begin
      if (!is_check_pos(pos)) begin
        cw[pos] = data_i[j];
        j++;
      end
    end
    for (int unsigned k = 0; k < SYN_WIDTH; k++) begin
      p = 1'b0;
      for (int unsigned pos = 1; pos < CW_WIDTH; pos++)
        if (pos[k]) p = p ^ cw[pos];
      cw[1 << k] = p;
    end
    cw[0]  = ^cw[CW_WIDTH-1:1];
    code_o = cw;
  end
endmodule

// File: rtl/seu_scrub_errlog.sv
// Saturating SEC/DED counters with clear priority, plus DED address log and irq pulse.
module seu_scrub_errlog #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              sec_i,
  input  logic              ded_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [CNT_W-1:0]  sec_cnt_o,
  output logic [CNT_W-1:0]  ded_cnt_o,
  output logic              ded_irq_o,
  output logic [ADDR_W-1:0] ded_addr_o
);
  // A clear coinciding with an event leaves a count of one so the event is kept.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic clr);
    if (clr) return inc ? CNT_W'(1) : '0;
    if (inc && (cnt != '1)) return cnt + 1'b1;
    return cnt;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sec_cnt_o  <= '0;
      ded_cnt_o  <= '0;
      ded_irq_o  <= 1'b0;
      ded_addr_o <= '0;
    end else begin
      sec_cnt_o <= cnt_next(sec_cnt_o, sec_i, clr_i);
      ded_cnt_o <= cnt_next(ded_cnt_o, ded_i, clr_i);
      ded_irq_o <= ded_i;
      if (ded_i)      ded_addr_o <= addr_i;
      else if (clr_i) ded_addr_o <= '0;
    end
  end
endmodule

// File: rtl/seu_mem_scrubber.sv
// Background SEC-DED scrubber: reads each word, writes back corrected singles, logs doubles.
module seu_mem_scrubber
  import seu_scrub_pkg::*;
#(
  parameter  int unsigned DEPTH    = 256,
  parameter  int unsigned INTERVAL = 1024,
  parameter  int unsigned CNT_W    = 16,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                clr_i,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [CW_WIDTH-1:0] mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [CW_WIDTH-1:0] mem_rdata_i,
  input  logic                snoop_we_i,
  input  logic [ADDR_W-1:0]   snoop_addr_i,
  output logic [CNT_W-1:0]    sec_cnt_o,
  output logic [CNT_W-1:0]    ded_cnt_o,
  output logic                ded_irq_o,
  output logic [ADDR_W-1:0]   ded_addr_o,
  output logic                pass_done_o
);
  localparam int unsigned IW = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;

  scrub_state_t          state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q;
  logic [IW-1:0]         ivl_q;
  logic [CW_WIDTH-1:0]   cap_q;
  logic                  stale_q;
  logic [DATA_WIDTH-1:0] dec_data;
  logic [SYN_WIDTH-1:0]  dec_syn;
  logic                  dec_par;
  logic                  hit, last, is_sec, is_ded, sec_evt, ded_evt;

  hamming32t26d_dec u_dec (.code_i(cap_q), .data_o(dec_data), .syndrome_o(dec_syn), .parity_o(dec_par));
  hamming32t26d_enc u_enc (.data_i(dec_data), .code_o(mem_wdata_o));

  assign hit        = snoop_we_i && (snoop_addr_i == ptr_q);
  assign last       = (ptr_q == ADDR_W'(DEPTH - 1));
  assign is_sec     = dec_par;
  assign is_ded     = !dec_par && (dec_syn != '0);
  assign mem_addr_o = ptr_q;

  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    sec_evt     = 1'b0;
    ded_evt     = 1'b0;
    pass_done_o = 1'b0;
    case (state_q)
      WAIT:  if (en_i && (ivl_q == '0)) state_d = RD;
      RD: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = RWAIT;
      end
      RWAIT: if (mem_rvalid_i) state_d = CHK;
      CHK: begin
        sec_evt = is_sec;
        ded_evt = is_ded;
        state_d = (is_sec && !(stale_q || hit)) ? WR : NEXT;
      end
      // A snoop hit withdraws the write in the same cycle so stale data never lands.
      WR: begin
        mem_req_o = !hit;
        mem_we_o  = !hit;
        if (hit || mem_gnt_i) state_d = NEXT;
      end
      NEXT: begin
        pass_done_o = last;
        state_d     = ((INTERVAL == 0) && en_i) ? RD : WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WAIT;
      ptr_q   <= '0;
      ivl_q   <= IW'(INTERVAL);
      cap_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        WAIT:  if (en_i && (ivl_q != '0)) ivl_q <= ivl_q - 1'b1;
        RD:    if (mem_gnt_i) stale_q <= hit;
        RWAIT: begin
          stale_q <= stale_q | hit;
          if (mem_rvalid_i) cap_q <= mem_rdata_i;
        end
        CHK, WR: stale_q <= stale_q | hit;
        NEXT: begin
          ptr_q <= last ? '0 : ptr_q + 1'b1;
          ivl_q <= IW'(INTERVAL);
        end
        default: ;
      endcase
    end
  end

  seu_scrub_errlog #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) u_errlog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (clr_i),
    .sec_i     (sec_evt),
    .ded_i     (ded_evt),
    .addr_i    (ptr_q),
    .sec_cnt_o (sec_cnt_o),
    .ded_cnt_o (ded_cnt_o),
    .ded_irq_o (ded_irq_o),
    .ded_addr_o(ded_addr_o)
  );
endmodule
